// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register backed by a 2-entry skid buffer with synchronous flush.
// Optional saturating stall counter port is built only when PIPE_SKID_STALL_CNT_EN is defined.
module pipe_skid_reg #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int unsigned      STALL_CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_t;

    cnt_t             state_q;
    cnt_t             state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             push;
    logic             pop;

    // Ready depends only on local state and flush, never on out_ready.
    assign in_ready  = (state_q != FULL) && !flush;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Occupancy transitions; main always holds the older entry.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Counts cycles where valid output is held off by downstream; survives flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios then random traffic against a queue model.
module tb_pipe_skid_reg;

    localparam int unsigned      WIDTH   = 32;
    localparam logic [WIDTH-1:0] RST_VAL = '0;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0]      stall_cnt;
    logic [1:0]       stall_cnt2;
    logic             in_ready2;
    logic             out_valid2;
    logic [WIDTH-1:0] out_data2;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] q[$];
    bit               fresh;
    int               stall_m;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(WIDTH), .RESET_VAL(RST_VAL), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef PIPE_SKID_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

`ifdef PIPE_SKID_STALL_CNT_EN
    pipe_skid_reg #(.WIDTH(WIDTH), .RESET_VAL(RST_VAL), .STALL_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
        .stall_cnt(stall_cnt2)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_stall();
`ifdef PIPE_SKID_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
        check("stall_cnt_w2", 32'(stall_cnt2), 32'((stall_m > 3) ? 3 : stall_m));
`endif
    endtask

    // One clock of stimulus: drive, check outputs against the model, then advance the model.
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        bit m_valid;
        bit m_ready;
        bit push;
        bit pop;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        m_valid = (q.size() != 0);
        m_ready = (q.size() < 2) && !fl;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("in_ready", 32'(in_ready), 32'(m_ready));
        if (m_valid) check("out_data", out_data, q[0]);
        else if (fresh) check("out_data_clear", out_data, RST_VAL);
        check("cnt_legal", 32'(dut.state_q != 2'd3), 32'd1);
`ifdef PIPE_SKID_STALL_CNT_EN
        check("dut2_out_valid", 32'(out_valid2), 32'(m_valid));
`endif
        check_stall();
        push = iv && m_ready;
        pop  = m_valid && ordy;
        @(posedge clk);
        if (m_valid && !ordy && stall_m < 65535) stall_m++;
        if (fl) begin
            q.delete();
            fresh = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(d);
                fresh = 1'b0;
            end
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react before any clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'(!flush));
        check("rst_out_data", out_data, RST_VAL);
        stall_m = 0;
        check_stall();
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        fresh = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        fresh = 1'b1; stall_m = 0;
        #1;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_out_data", out_data, RST_VAL);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset while FULL
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Full-rate streaming
        for (int i = 0; i < 8; i++) step(1'b1, 32'hA0 + 32'(i), 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure then drain in order
        step(1'b1, 32'h1, 1'b0, 1'b0);
        step(1'b1, 32'h2, 1'b0, 1'b0);
        step(1'b1, 32'h3, 1'b0, 1'b0);
        step(1'b1, 32'h3, 1'b1, 1'b0);
        step(1'b1, 32'h3, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while FULL with a concurrent offer
        step(1'b1, 32'h5, 1'b0, 1'b0);
        step(1'b1, 32'h6, 1'b0, 1'b0);
        step(1'b1, 32'h7, 1'b0, 1'b1);
        step(1'b1, 32'h8, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Push and pop together in ONE
        step(1'b1, 32'h10, 1'b0, 1'b0);
        step(1'b1, 32'h20, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Stall accumulation, flush retention, reset clear
        step(1'b1, 32'h55, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        do_reset();

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 24) == 0));
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
